// File: rtl/fifo_pkg.sv
// Shared FIFO package: pointer-width helper and error bit indices.
// Reused by the FIFOs of this codebase.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ch_ctrl.sv
// One channel of sync_fifo_mc: pointers, count, flags, sticky errors.
// Error bits exist only when SYNC_FIFO_MC_ERR_EN is defined.
module sync_fifo_ch_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PW      = ptr_width(DEPTH),
  localparam int AW      = PW - 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic             ovf_evt_i,
  input  logic             udf_evt_i,
  input  logic             err_clr_i,
  output logic [AW-1:0]    waddr_o,
  output logic [AW-1:0]    raddr_o,
  output logic [PW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o,
  output logic [ERR_W-1:0] err_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          afull_q, aempty_q;

  always_comb begin
    wptr_d = wptr_q + PW'(wr_i);
    rptr_d = rptr_q + PW'(rd_i);
    unique case ({wr_i, rd_i})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags come from the next count so they track state with no lag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == PW'(DEPTH));
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= PW'(AF_LEVEL));
      aempty_q <= (cnt_d <= PW'(AE_LEVEL));
    end
  end

  assign waddr_o  = wptr_q[AW-1:0];
  assign raddr_o  = rptr_q[AW-1:0];
  assign count_o  = cnt_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;

`ifdef SYNC_FIFO_MC_ERR_EN
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = '0;
    end else begin
      if (ovf_evt_i) err_d[ERR_OVF] = 1'b1;
      if (udf_evt_i) err_d[ERR_UDF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_q <= '0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = ^{ovf_evt_i, udf_evt_i, err_clr_i};
  assign err_o      = '0;
`endif

endmodule

// File: rtl/sync_fifo_mc.sv
// Single-clock multi-channel FIFO over one shared memory.
// Sticky overflow/underflow enabled by SYNC_FIFO_MC_ERR_EN.
module sync_fifo_mc
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CH_WIDTH   = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  wEn,
  input  logic [CH_WIDTH-1:0]   wCh,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  rEn,
  input  logic [CH_WIDTH-1:0]   rCh,
  output logic [DATA_WIDTH-1:0] rData,
  output logic [ADDR_WIDTH:0]   rLevel,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     almostFull,
  output logic [NUM_CH-1:0]     almostEmpty,
  input  logic                  errClr,
  output logic [NUM_CH-1:0]     overflow,
  output logic [NUM_CH-1:0]     underflow
);

  localparam int MW = CH_WIDTH + ADDR_WIDTH;

  logic                                  rAcc, wAcc;
  logic [NUM_CH-1:0]                     wr, rd;
  logic [NUM_CH-1:0]                     ovf_evt, udf_evt;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     waddr, raddr;
  logic [NUM_CH-1:0][ADDR_WIDTH:0]       cnt;
  logic [NUM_CH-1:0][ERR_W-1:0]          err;
  logic [DATA_WIDTH-1:0]                 mem_q [2**MW];

  // A full channel still takes a write when it is popped this cycle.
  assign rAcc = rEn & ~empty[rCh];
  assign wAcc = wEn & (~full[wCh] | (rAcc & (rCh == wCh)));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c]      = wAcc & (wCh == CH_WIDTH'(c));
    assign rd[c]      = rAcc & (rCh == CH_WIDTH'(c));
    assign ovf_evt[c] = wEn & ~wAcc & (wCh == CH_WIDTH'(c));
    assign udf_evt[c] = rEn & ~rAcc & (rCh == CH_WIDTH'(c));

    sync_fifo_ch_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
      .clk       (clk),
      .arst_n    (arst_n),
      .wr_i      (wr[c]),
      .rd_i      (rd[c]),
      .ovf_evt_i (ovf_evt[c]),
      .udf_evt_i (udf_evt[c]),
      .err_clr_i (errClr),
      .waddr_o   (waddr[c]),
      .raddr_o   (raddr[c]),
      .count_o   (cnt[c]),
      .full_o    (full[c]),
      .empty_o   (empty[c]),
      .afull_o   (almostFull[c]),
      .aempty_o  (almostEmpty[c]),
      .err_o     (err[c])
    );

    assign overflow[c]  = err[c][ERR_OVF];
    assign underflow[c] = err[c][ERR_UDF];
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wAcc) mem_q[MW'({wCh, waddr[wCh]})] <= wData;
  end

  assign rData  = mem_q[MW'({rCh, raddr[rCh]})];
  assign rLevel = cnt[rCh];

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Bench for sync_fifo_mc: directed cases plus random traffic
// checked against per-channel queue models.
module tb_sync_fifo_mc;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NCH   = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;
`ifdef SYNC_FIFO_MC_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          wEn = 1'b0, rEn = 1'b0, errClr = 1'b0;
  logic [1:0]    wCh = '0, rCh = '0;
  logic [DW-1:0] wData = '0;
  logic [DW-1:0] rData;
  logic [2:0]    rLevel;
  logic [3:0]    full, empty, almostFull, almostEmpty;
  logic [3:0]    overflow, underflow;

  sync_fifo_mc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH),
    .AF_LEVEL   (AFL),
    .AE_LEVEL   (AEL)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .wEn         (wEn),
    .wCh         (wCh),
    .wData       (wData),
    .rEn         (rEn),
    .rCh         (rCh),
    .rData       (rData),
    .rLevel      (rLevel),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .errClr      (errClr),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pops  = 0;

  logic [DW-1:0] mq [NCH][$];
  logic [3:0]    m_ovf = '0;
  logic [3:0]    m_udf = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] f, e, af, ae;
    for (int c = 0; c < NCH; c++) begin
      f[c]  = (mq[c].size() == DEPTH);
      e[c]  = (mq[c].size() == 0);
      af[c] = (mq[c].size() >= AFL);
      ae[c] = (mq[c].size() <= AEL);
    end
    chk("full", 32'(full), 32'(f));
    chk("empty", 32'(empty), 32'(e));
    chk("almostFull", 32'(almostFull), 32'(af));
    chk("almostEmpty", 32'(almostEmpty), 32'(ae));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("rLevel", 32'(rLevel), 32'(mq[rCh].size()));
    if (mq[rCh].size() != 0) chk("rData", rData, mq[rCh][0]);
  endtask

  task automatic step(input bit we, input logic [1:0] wc,
                      input logic [DW-1:0] wd, input bit re,
                      input logic [1:0] rc, input bit clr);
    bit racc, wacc;
    wEn = we; wCh = wc; wData = wd;
    rEn = re; rCh = rc; errClr = clr;
    racc = re && (mq[rc].size() != 0);
    wacc = we && ((mq[wc].size() < DEPTH) || (racc && rc == wc));
    @(posedge clk);
    #1;
    if (racc) begin
      void'(mq[rc].pop_front());
      pops++;
    end
    if (wacc) mq[wc].push_back(wd);
    if (ERR) begin
      if (clr) begin
        m_ovf = '0;
        m_udf = '0;
      end else begin
        if (we && !wacc) m_ovf[wc] = 1'b1;
        if (re && !racc) m_udf[rc] = 1'b1;
      end
    end
    check_all();
  endtask

  task automatic idle(input logic [1:0] rc);
    step(1'b0, 2'd0, '0, 1'b0, rc, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] exp1 [4];
    exp1 = '{32'h11, 32'h12, 32'h13, 32'h55};

    #12 arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'hF);
    check_all();

    // fill ch2, overflow, read back in order
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 32'hA0 + i, 1'b0, 2'd2, 1'b0);
    chk("full2", 32'(full[2]), 32'd1);
    chk("af2", 32'(almostFull[2]), 32'd1);
    chk("others_empty", 32'(empty), 32'b1011);
    step(1'b1, 2'd2, 32'hA4, 1'b0, 2'd2, 1'b0);
    chk("ovf2", 32'(overflow[2]), 32'(ERR));
    chk("lvl2", 32'(rLevel), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rb2", rData, 32'hA0 + i);
      step(1'b0, 2'd0, '0, 1'b1, 2'd2, 1'b0);
    end
    chk("empty2", 32'(empty[2]), 32'd1);

    // simultaneous push/pop on full ch1
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 32'h10 + i, 1'b0, 2'd1, 1'b0);
    step(1'b1, 2'd1, 32'h55, 1'b1, 2'd1, 1'b0);
    chk("lvl1", 32'(rLevel), 32'd4);
    chk("full1", 32'(full[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("rb1", rData, exp1[i]);
      step(1'b0, 2'd0, '0, 1'b1, 2'd1, 1'b0);
    end

    // push/pop on empty ch0: no bypass
    step(1'b1, 2'd0, 32'h77, 1'b1, 2'd0, 1'b0);
    chk("udf0", 32'(underflow[0]), 32'(ERR));
    chk("lvl0", 32'(rLevel), 32'd1);
    chk("rd0", rData, 32'h77);
    step(1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);

    // errClr beats a same-cycle overflow
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 32'h30 + i, 1'b0, 2'd3, 1'b0);
    step(1'b1, 2'd3, 32'h99, 1'b0, 2'd3, 1'b1);
    chk("clr_ovf3", 32'(overflow[3]), 32'd0);
    step(1'b1, 2'd3, 32'h9A, 1'b0, 2'd3, 1'b0);
    chk("ovf3", 32'(overflow[3]), 32'(ERR));
    step(1'b0, 2'd0, '0, 1'b0, 2'd3, 1'b1);
    chk("clr_all", 32'({overflow, underflow}), 32'd0);

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)),
           $urandom_range(0, 199) == 0);
    end
    $display("random phase pops=%0d (~%0d pointer wraps)", pops, pops / (2 * DEPTH));

    // async reset mid-stream, with pending data and errors
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'hC0 + i, 1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 32'hD0, 1'b0, 2'd0, 1'b0);
    wEn = 1'b0; rEn = 1'b0; errClr = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'hF);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_af", 32'(almostFull), 32'd0);
    chk("arst_ae", 32'(almostEmpty), 32'hF);
    chk("arst_lvl", 32'(rLevel), 32'd0);
    chk("arst_err", 32'({overflow, underflow}), 32'd0);
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_ovf = '0;
    m_udf = '0;
    #3 arst_n = 1'b1;
    idle(2'd0);
    step(1'b1, 2'd0, 32'hE1, 1'b0, 2'd0, 1'b0);
    chk("post_rst", rData, 32'hE1);
    step(1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_mc.md
# sync_fifo_mc

Single-clock, multi-channel FIFO: NUM_CH independent queues of DEPTH words sharing one memory, with one write port and one read port, each steered by a channel select. It is the single-clock, multi-queue successor to the team's dual-clock FIFO. It adds per-channel full/empty/almost flags, a selected-channel fill level, simultaneous read/write on a full channel, and optional sticky error reporting. It sits between multi-source producers and a shared consumer, for example per-stream buffering ahead of an arbiter.

## Interface
- DATA_WIDTH, 32: word width.
- DEPTH, 16: words per channel. Power of 2, ≥2.
- NUM_CH, 4: channel count. Power of 2, ≥2.
- AF_LEVEL, DEPTH-2: almostFull[c] asserts when count[c] ≥ AF_LEVEL.
- AE_LEVEL, 2: almostEmpty[c] asserts when count[c] ≤ AE_LEVEL.
- Derived: ADDR_WIDTH = $clog2(DEPTH); CH_WIDTH = $clog2(NUM_CH).
- clk, in, 1: the single clock. All state is updated on the rising edge.
- arst_n, in, 1: reset, asynchronous assert, active-low.
- wEn, in, 1: write request.
- wCh, in, CH_WIDTH: write channel.
- wData, in, DATA_WIDTH: write data.
- rEn, in, 1: read (pop) request.
- rCh, in, CH_WIDTH: read channel.
- rData, out, DATA_WIDTH: head word of channel rCh. Combinational from rCh and the registered state.
- rLevel, out, ADDR_WIDTH+1: count of channel rCh. Combinational mux of registered counts.
- full, empty, almostFull, almostEmpty: out, NUM_CH each. Registered per-channel flags.
- errClr, in, 1: clears the sticky error flags.
- overflow, underflow: out, NUM_CH each. Sticky per-channel error flags.

## Operation
- Per-channel state:
  - wPtr and rPtr, each ADDR_WIDTH+1 bits binary. Wrap is natural modulo 2^(ADDR_WIDTH+1).
  - count, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Memory address is {ch, ptr[ADDR_WIDTH-1:0]}. Memory contents are not reset.
- Read accept: rAcc = rEn & ~empty[rCh].
- Write accept: wAcc = wEn & (~full[wCh] | (rAcc & rCh==wCh)).
  - A full channel therefore accepts a write in the same cycle it is popped.
- Rejected requests change no pointer, count or memory word.
- Count update per channel:
  - write only: +1.
  - read only: −1.
  - both accepted on the same channel: unchanged.
- A read of an empty channel is rejected even if the same channel is written in that cycle. There is no bypass.
- Flags are computed from the next count and registered:
  - full = count==DEPTH.
  - empty = count==0.
  - almostFull / almostEmpty per the thresholds above.
- Wrap-around: when count==DEPTH, wPtr and rPtr differ only in the MSB. Pointers wrap indefinitely with no loss.
- Reset (async, at any time, including mid-transfer):
  - all pointers and counts return to 0.
  - empty='1, almostEmpty='1 (AE_LEVEL≥0).
  - full='0, almostFull='0.
  - overflow/underflow='0.
  - rLevel=0. rData is undefined until the first write.

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N:
  - appears on rData (when selected) after edge N.
  - clears empty after edge N.
- A pop at edge N advances rData to the next word after edge N.
- Flags and rLevel reflect the state after the most recent edge. There is no extra pipeline stage.
- Throughput: one write and one read per cycle, on any channels.

## Configuration
- SYNC_FIFO_MC_ERR_EN defined:
  - overflow[c] sets on wEn to channel c that is not accepted.
  - underflow[c] sets on rEn to channel c that is not accepted.
  - Both are sticky until errClr. errClr has priority over a same-cycle set.
- SYNC_FIFO_MC_ERR_EN undefined:
  - overflow/underflow are tied to 0 and errClr is ignored.
  - Write/read gating is identical in both builds.

## Structure
- Shared package fifo_pkg: ptr_width(depth) helper and the ERR bit-index constants. It is reused by the other FIFOs in the codebase.
- Sub-module sync_fifo_ch_ctrl: one channel's pointers, count, flags and error bits. It is instantiated NUM_CH times in a generate loop.
- The top level holds the memory, the accept logic and the rData/rLevel muxes.

## Test plan
All scenarios use DEPTH=4, NUM_CH=4, AF_LEVEL=3, AE_LEVEL=1.
- Reset: assert arst_n=0 mid-stream → empty=4'b1111, full=0, rLevel=0 asynchronously. Errors clear.
- Fill ch2 with 0xA0..0xA3 → full[2]=1 and almostFull[2]=1 after the 4th edge; other channels stay empty. A 5th write of 0xA4 is dropped, overflow[2]=1 (ERR_EN), and the readback sequence is 0xA0..0xA3.
- Full ch1, rEn and wEn on ch1 with 0x55 in the same cycle → count stays 4, full[1] stays 1. The drained sequence ends in 0x55.
- Empty ch0, rEn and wEn on ch0 in the same cycle → read rejected, underflow[0]=1, count becomes 1, rData becomes the written word on the next cycle.
- Interleaved random writes/reads on all 4 channels for 10k cycles vs. per-channel scoreboard queues → data order, rLevel and all flags match every cycle. Pointer wrap is exercised more than 100 times.
- errClr with a same-cycle overflow event → flag reads 0. Without SYNC_FIFO_MC_ERR_EN, the error flags stay 0 throughout.
